// File: rtl/mdu_pkg.sv
// mdu_pkg: definitions shared by decode, the MDU datapath and the MDU
// sequencing controller.
//   - 4-bit MDU op codes carried down the pipeline with each instruction
//   - controller state encoding
//   - is_md / is_mt classification helpers
package mdu_pkg;

    localparam logic [3:0] NOP   = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] MULTU = 4'd2;
    localparam logic [3:0] DIV   = 4'd3;
    localparam logic [3:0] DIVU  = 4'd4;
    localparam logic [3:0] MFHI  = 4'd5;
    localparam logic [3:0] MFLO  = 4'd6;
    localparam logic [3:0] MTHI  = 4'd7;
    localparam logic [3:0] MTLO  = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    // Multi-cycle arithmetic ops that occupy the unit.
    function automatic logic is_md(input logic [3:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

    // Single-cycle direct writes to HI/LO.
    function automatic logic is_mt(input logic [3:0] op);
        return (op == MTHI) || (op == MTLO);
    endfunction

endpackage

// File: rtl/mdu_lat_cnt.sv
// mdu_lat_cnt: loadable down-counter with a zero flag, used to time the
// fixed latency of multi-cycle units.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (count -> 0)
//   load        : load load_val on this edge (has priority over dec)
//   load_val    : value to load
//   dec         : decrement on this edge; ignored once the count is 0
//   cnt         : current count
//   zero        : cnt == 0
module mdu_lat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    assign zero = (cnt == '0);

    // Saturates at zero so a stray dec can never wrap the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !zero) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: sequencing controller for the multi-cycle multiply/divide unit
// in the E stage. Issues start pulses, times the fixed mult/div latencies,
// generates the HI/LO commit and mthi/mtlo write enables, and stalls D
// while a result is pending.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   op_e, op_d : MDU op codes of the instructions in E and D
//   req        : exception/interrupt flush of the E-stage instruction
//   start      : (comb) datapath latches operands/op on this edge
//   op_div     : (reg) running op is div/divu
//   busy       : (reg) operation in flight
//   commit     : (comb) HI_temp/LO_temp -> HI/LO on this edge
//   hi_we      : (comb) mthi write on this edge
//   lo_we      : (comb) mtlo write on this edge
//   stall      : (comb) hold the D stage
//   proto_err  : (reg, sticky) MDU op reached E while busy
//   state_dbg  : current FSM state, for observation
//   cnt_dbg    : current latency count, for observation
//
// Handshake: start is a single-cycle strobe with no back-pressure; the
// datapath must accept it on the edge it is high. commit is likewise a
// single-cycle strobe. Upstream correctness relies on stall: while stall
// is high the D instruction must not advance into E.
//
// MUL_LAT, DIV_LAT >= 1 and 2**CNT_W > max(MUL_LAT, DIV_LAT) are required.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op_e,
    input  logic [3:0]       op_d,
    input  logic             req,
    output logic             start,
    output logic             op_div,
    output logic             busy,
    output logic             commit,
    output logic             hi_we,
    output logic             lo_we,
    output logic             stall,
    output logic             proto_err,
    output mdu_state_e       state_dbg,
    output logic [CNT_W-1:0] cnt_dbg
);

    // The counter holds LAT-1 in the first RUN cycle and commit fires when it
    // reaches 0, giving exactly LAT busy cycles after the issue edge.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    mdu_state_e       state_q, state_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] cnt;
    logic             op_e_div;
    logic             proto_set;

    assign op_e_div = (op_e == DIV) || (op_e == DIVU);

    mdu_lat_cnt #(
        .W(CNT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (load_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        commit    = 1'b0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        proto_set = 1'b0;
        load_val  = MUL_LOAD;
        case (state_q)
            IDLE: begin
                // A flushed (req) instruction never executes.
                if (is_md(op_e) && !req) begin
                    start    = 1'b1;
                    cnt_load = 1'b1;
                    load_val = op_e_div ? DIV_LOAD : MUL_LOAD;
                    state_d  = RUN;
                end
                hi_we = (op_e == MTHI) && !req;
                lo_we = (op_e == MTLO) && !req;
            end
            RUN: begin
                // req is ignored here: the running op has already left E.
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
                // An MDU op in E while busy means stall was not honoured;
                // drop it and flag the violation.
                if (is_md(op_e) || is_mt(op_e)) begin
                    proto_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_div    <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (start) begin
                op_div <= op_e_div;
            end
            if (proto_set) begin
                proto_err <= 1'b1;
            end
        end
    end

    assign busy = (state_q == RUN);

    // busy covers the commit cycle too, so a dependent mfhi/mflo in D only
    // enters E once HI/LO hold the new result.
    assign stall = (op_d != NOP) && (busy || is_md(op_e));

    assign state_dbg = state_q;
    assign cnt_dbg   = cnt;

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
    import mdu_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] op_e = NOP;
    logic [3:0] op_d = NOP;
    logic       req = 1'b0;

    logic       start, op_div, busy, commit, hi_we, lo_we, stall, proto_err;
    mdu_state_e state_dbg;
    logic [3:0] cnt_dbg;

    always #5 clk = ~clk;

    mdu_ctrl #(
        .MUL_LAT(5),
        .DIV_LAT(10),
        .CNT_W  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .op_e      (op_e),
        .op_d      (op_d),
        .req       (req),
        .start     (start),
        .op_div    (op_div),
        .busy      (busy),
        .commit    (commit),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .stall     (stall),
        .proto_err (proto_err),
        .state_dbg (state_dbg),
        .cnt_dbg   (cnt_dbg)
    );

    // ---------------- scoreboard ----------------
    // Expected vector bit order: {start, op_div, busy, commit, hi_we, lo_we, stall, proto_err}
    logic [7:0] exp_q[$];
    string      name_q[$];
    int         n_compared = 0;
    int         n_mismatched = 0;

    // Driver: apply one cycle of inputs shortly after the rising edge and
    // queue the hand-computed outputs for that cycle.
    task automatic step(input logic rst, input logic [3:0] e, input logic [3:0] d,
                        input logic r, input logic [7:0] exp, input string nm);
        @(posedge clk);
        #1;
        reset = rst;
        op_e  = e;
        op_d  = d;
        req   = r;
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    // Monitor: sample mid-cycle (falling edge) and check against the queue.
    initial begin
        logic [7:0] act, exp;
        string      nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = {start, op_div, busy, commit, hi_we, lo_we, stall, proto_err};
                n_compared++;
                if (act !== exp) begin
                    n_mismatched++;
                    $display("FAIL %s: got %b expected %b (start,op_div,busy,commit,hi_we,lo_we,stall,proto_err)",
                             nm, act, exp);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        // Reset state
        step(1, NOP, NOP, 0, 8'b0000_0000, "reset_0");
        step(1, NOP, NOP, 0, 8'b0000_0000, "reset_1");
        step(0, NOP, NOP, 0, 8'b0000_0000, "idle_after_reset");

        // MULT with dependent mflo in D
        step(0, MULT, MFLO, 0, 8'b1000_0010, "mult_c0_issue");
        for (int i = 1; i <= 4; i++)
            step(0, NOP, MFLO, 0, 8'b0010_0010, $sformatf("mult_c%0d_busy", i));
        step(0, NOP, MFLO, 0, 8'b0011_0010, "mult_c5_commit");
        step(0, NOP, MFLO, 0, 8'b0000_0000, "mult_c6_stall_drop");
        step(0, MFLO, NOP, 0, 8'b0000_0000, "mflo_in_e_no_action");

        // DIVU then back-to-back MULTU
        step(0, DIVU, NOP, 0, 8'b1000_0000, "divu_c0_issue");
        for (int i = 1; i <= 9; i++)
            step(0, NOP, NOP, 0, 8'b0110_0000, $sformatf("divu_c%0d_busy", i));
        step(0, NOP, NOP, 0, 8'b0111_0000, "divu_c10_commit");
        step(0, MULTU, NOP, 0, 8'b1100_0000, "multu_c11_issue");
        for (int i = 12; i <= 15; i++)
            step(0, NOP, NOP, 0, 8'b0010_0000, $sformatf("multu_c%0d_busy", i));
        step(0, NOP, NOP, 0, 8'b0011_0000, "multu_c16_commit");
        step(0, NOP, NOP, 0, 8'b0000_0000, "multu_c17_idle");

        // Flushes and direct writes in IDLE
        step(0, DIV,  NOP,  1, 8'b0000_0000, "div_flushed_no_start");
        step(0, NOP,  NOP,  0, 8'b0000_0000, "div_flushed_not_busy");
        step(0, MTHI, NOP,  1, 8'b0000_0000, "mthi_flushed");
        step(0, MTLO, NOP,  0, 8'b0000_0100, "mtlo_write");
        step(0, MTHI, MFHI, 0, 8'b0000_1000, "mthi_write_no_stall");
        step(0, NOP,  MFHI, 0, 8'b0000_0000, "idle_op_d_no_stall");

        // req during RUN does not abort
        step(0, MULT, NOP, 0, 8'b1000_0000, "req_run_c0_issue");
        step(0, NOP,  NOP, 0, 8'b0010_0000, "req_run_c1");
        step(0, NOP,  NOP, 1, 8'b0010_0000, "req_run_c2_req");
        step(0, NOP,  NOP, 0, 8'b0010_0000, "req_run_c3");
        step(0, NOP,  NOP, 0, 8'b0010_0000, "req_run_c4");
        step(0, NOP,  NOP, 0, 8'b0011_0000, "req_run_c5_commit");
        step(0, NOP,  NOP, 0, 8'b0000_0000, "req_run_c6_idle");

        // Protocol violation: mthi while busy
        step(0, MULT, NOP, 0, 8'b1000_0000, "proto_c0_issue");
        step(0, NOP,  NOP, 0, 8'b0010_0000, "proto_c1");
        step(0, NOP,  NOP, 0, 8'b0010_0000, "proto_c2");
        step(0, MTHI, NOP, 0, 8'b0010_0000, "proto_c3_mthi_ignored");
        step(0, NOP,  NOP, 0, 8'b0010_0001, "proto_c4_err_set");
        step(0, NOP,  NOP, 0, 8'b0011_0001, "proto_c5_commit");
        step(0, NOP,  NOP, 0, 8'b0000_0001, "proto_c6_sticky");
        step(0, MTLO, NOP, 0, 8'b0000_0101, "proto_sticky_mtlo");

        // Reset mid-RUN at cnt=3 (cycle 2)
        step(0, MULT, NOP, 0, 8'b1000_0001, "rst_run_c0_issue");
        step(0, NOP,  NOP, 0, 8'b0010_0001, "rst_run_c1");
        step(1, NOP,  NOP, 0, 8'b0000_0000, "rst_run_c2_reset");
        step(1, NOP,  NOP, 0, 8'b0000_0000, "rst_run_c3_reset");
        for (int i = 4; i <= 7; i++)
            step(0, NOP, NOP, 0, 8'b0000_0000, $sformatf("rst_run_c%0d_no_commit", i));
        step(0, DIV, MFHI, 0, 8'b1000_0010, "after_reset_div_issue");
        step(0, NOP, MFHI, 0, 8'b0110_0010, "after_reset_div_busy");

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Sequencing controller for the multi-cycle multiply/divide unit in the E stage of the pipelined MIPS core. It decodes the E-stage and D-stage MDU op codes and issues start pulses to the arithmetic datapath. It times the fixed multiply/divide latencies, generates HI/LO commit and write enables, and produces the D-stage stall. Exception/interrupt requests (req) suppress issue of the instruction currently in E.

Parameters:
MUL_LAT, 5, cycles from issue edge to commit for mult/multu (>=1)
DIV_LAT, 10, cycles from issue edge to commit for div/divu (>=1)
CNT_W, 4, latency counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
op_e  in  4  MDU op code of instruction in E stage
op_d  in  4  MDU op code of instruction in D stage
req  in  1  exception/interrupt flush of the E-stage instruction
start  out  1  comb.: datapath latches operands and op on this clk edge
op_div  out  1  registered: 1 = running op is div/divu, 0 = mult/multu
busy  out  1  registered: operation in flight (state != IDLE)
commit  out  1  comb.: copy HI_temp/LO_temp into HI/LO on this edge
hi_we  out  1  comb.: mthi write to HI on this edge
lo_we  out  1  comb.: mtlo write to LO on this edge
stall  out  1  comb.: hold D stage
proto_err  out  1  registered, sticky: op_e mult/div/mt* arrived while busy

Behaviour:
- Reset (async, reset=1): state=IDLE, cnt=0, op_div=0, busy=0, proto_err=0; all comb. outputs evaluate to 0 with op_e=op_d=NOP.
- is_md(x) = x in {MULT, MULTU, DIV, DIVU}. is_mt(x) = x in {MTHI, MTLO}.
- FSM states: IDLE, RUN.
- IDLE: issue = is_md(op_e) && !req. start = issue. On that edge: state<=RUN, cnt<=LAT-1 (DIV_LAT for div/divu, MUL_LAT otherwise), op_div latched.
- IDLE: hi_we = (op_e==MTHI) && !req; lo_we = (op_e==MTLO) && !req. No state change.
- req=1 in IDLE suppresses start, hi_we and lo_we for that cycle; the flushed instruction never executes.
- RUN: cnt decrements each edge. commit = (state==RUN && cnt==0). On the commit edge: state<=IDLE. busy is high for exactly LAT cycles after the issue edge.
- req during RUN does not abort: the issued instruction has already passed E and completes normally.
- RUN with is_md(op_e) or is_mt(op_e): op is ignored (no start/we) and proto_err<=1. Correct stall prevents this case.
- stall = (op_d != NOP) && (busy || is_md(op_e)). The stall stays high through the commit cycle, so a D-stage mfhi/mflo enters E only after HI/LO have been updated.
- mfhi/mflo in E: the controller takes no action; the read path is combinational in the datapath.
- Back-to-back: after commit the next cycle is IDLE and can issue immediately.
- Reset mid-RUN: returns to IDLE immediately, with no commit and discarded temp result.
- The counter never wraps: it loads only in IDLE and stops at 0.

Decomposition:
- Shared package mdu_pkg: 4-bit op constants NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8; state encoding IDLE/RUN; is_md/is_mt helper functions. The package is shared with decode and the MDU datapath.
- One natural sub-module, mdu_lat_cnt: loadable down-counter with a zero flag, reused by any future multi-cycle unit.

Test Plan:
- Reset asserted mid-RUN (cnt=3), then released -> busy=0, commit never pulses, proto_err=0, state IDLE next cycle.
- op_e=MULT, op_d=MFLO at cycle 0 -> start=1 at cycle 0. busy=1 in cycles 1-5, commit=1 in cycle 5 only, stall=1 in cycles 0-5, stall=0 in cycle 6.
- op_e=DIVU at cycle 0 -> busy=1 in cycles 1-10, commit in cycle 10, op_div=1. New op_e=MULTU at cycle 11 -> start=1 at cycle 11.
- op_e=DIV with req=1 -> start=0, busy stays 0. op_e=MTHI with req=1 -> hi_we=0. op_e=MTLO with req=0 -> lo_we=1 in that cycle.
- MULT issued, req=1 pulsed in cycle 2 -> operation continues, commit still in cycle 5.
- Force op_e=MTHI in cycle 3 of RUN -> hi_we=0, proto_err=1 and sticky until reset.
